global_avg_pool_stream: RTL and testbench

GLOBAL_AVG_POOL_STREAM -- requirements
Module: global_avg_pool_stream

---
 rtl/global_avg_pool_stream_if.sv | 27 ++
 rtl/global_avg_pool_stream.sv | 120 ++++++++++++
 tb/tb_global_avg_pool_stream.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/global_avg_pool_stream_if.sv
// Stream bundle for the global average pool: sample input side plus
// pooled-result output side with its own backpressure.
interface global_avg_pool_stream_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic [7:0]                   channel_in;
  logic [7:0]                   row_in;
  logic [7:0]                   col_in;
  logic                         ready;
  logic                         valid_out;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic [7:0]                   channel_out;
  logic                         out_ready;
  logic                         frame_done;

  modport slave (
    input  valid_in, data_in, channel_in, row_in, col_in, out_ready,
    output ready, valid_out, data_out, channel_out, frame_done
  );

  modport master (
    output valid_in, data_in, channel_in, row_in, col_in, out_ready,
    input  ready, valid_out, data_out, channel_out, frame_done
  );
endinterface

// File: rtl/global_avg_pool_stream.sv
// Global average pooling over a streamed feature map: per-channel signed
// accumulation in ACCUM, then one saturated average per channel in DRAIN.
module global_avg_pool_stream #(
  parameter int CHANNELS     = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int FEATURE_SIZE = 7,
  parameter int RECIP        = 65536 / (FEATURE_SIZE * FEATURE_SIZE)
) (
  input logic                        clk,
  input logic                        rst_n,
  global_avg_pool_stream_if.slave    bus
);
  localparam int ACC_W  = DATA_WIDTH + 2 * $clog2(FEATURE_SIZE) + 1;
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PROD_W = ACC_W + 18;
  localparam int SMAX_I = 2 ** (DATA_WIDTH - 1) - 1;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic [IDX_W-1:0]         LAST    = IDX_W'(CHANNELS - 1);
  localparam logic [16:0]              RECIP_U = 17'(RECIP);
  localparam logic signed [PROD_W-1:0] SMAX    = PROD_W'(SMAX_I);
  localparam logic signed [PROD_W-1:0] SMIN    = PROD_W'(-SMAX_I - 1);

  logic [0:0]                   state_q, state_d;
  logic signed [ACC_W-1:0]      acc_q [CHANNELS];
  logic signed [ACC_W-1:0]      acc_d [CHANNELS];
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         vo_q, vo_d;
  logic                         fd_q, fd_d;
  logic signed [DATA_WIDTH-1:0] do_q, do_d;
  logic [7:0]                   co_q, co_d;

  logic                         accept, frame_end, pop, last_pop;
  logic [IDX_W-1:0]             rd_idx;
  logic signed [PROD_W-1:0]     acc_ext, rec_ext, prod, shifted;
  logic signed [DATA_WIDTH-1:0] avg;

  // Samples only land while accumulating and for in-range channels.
  assign accept    = (state_q == ACCUM) && bus.valid_in &&
                     (int'(bus.channel_in) < CHANNELS);
  assign frame_end = accept && (bus.channel_in == 8'(CHANNELS - 1)) &&
                     (bus.row_in == 8'(FEATURE_SIZE - 1)) &&
                     (bus.col_in == 8'(FEATURE_SIZE - 1));
  assign pop       = (state_q == DRAIN) && vo_q && bus.out_ready;
  assign last_pop  = pop && (idx_q == LAST);
  // Look one channel ahead on a pop so results stream one per cycle.
  assign rd_idx    = (pop && !last_pop) ? idx_q + 1'b1 : idx_q;

  // Fixed-point divide by FEATURE_SIZE^2: multiply by reciprocal, floor shift, clamp.
  always_comb begin
    acc_ext = PROD_W'(acc_q[rd_idx]);
    rec_ext = PROD_W'($signed({1'b0, RECIP_U}));
    prod    = acc_ext * rec_ext;
    shifted = prod >>> 16;
    if (shifted > SMAX)      avg = DATA_WIDTH'(SMAX_I);
    else if (shifted < SMIN) avg = DATA_WIDTH'(-SMAX_I - 1);
    else                     avg = DATA_WIDTH'(shifted);
  end

  // Next-state: accumulate, detect frame end, then drain channel by channel.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vo_d    = vo_q;
    fd_d    = 1'b0;
    do_d    = do_q;
    co_d    = co_q;
    acc_d   = acc_q;
    if (accept)
      acc_d[bus.channel_in[IDX_W-1:0]] = acc_q[bus.channel_in[IDX_W-1:0]] +
                                         ACC_W'(bus.data_in);
    if (frame_end) begin
      state_d = DRAIN;
      idx_d   = '0;
    end
    if ((state_q == DRAIN) && (!vo_q || pop)) begin
      if (last_pop) begin
        for (int i = 0; i < CHANNELS; i++) acc_d[i] = '0;
        vo_d    = 1'b0;
        fd_d    = 1'b1;
        state_d = ACCUM;
        idx_d   = '0;
      end else begin
        vo_d  = 1'b1;
        do_d  = avg;
        co_d  = 8'(rd_idx);
        idx_d = rd_idx;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      vo_q    <= 1'b0;
      fd_q    <= 1'b0;
      do_q    <= '0;
      co_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vo_q    <= vo_d;
      fd_q    <= fd_d;
      do_q    <= do_d;
      co_q    <= co_d;
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign bus.ready       = (state_q == ACCUM);
  assign bus.valid_out   = vo_q;
  assign bus.data_out    = do_q;
  assign bus.channel_out = co_q;
  assign bus.frame_done  = fd_q;
endmodule

// File: tb/tb_global_avg_pool_stream.sv
// Directed bench: three pool instances (FS=2, FS=3, FS=2 with a larger
// reciprocal) share one stimulus bus, selected by 'sel'.
module tb_global_avg_pool_stream;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  global_avg_pool_stream_if #(.DATA_WIDTH(16)) if0 ();
  global_avg_pool_stream_if #(.DATA_WIDTH(16)) if1 ();
  global_avg_pool_stream_if #(.DATA_WIDTH(16)) if2 ();

  global_avg_pool_stream #(.CHANNELS(4), .DATA_WIDTH(16), .FEATURE_SIZE(2))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  global_avg_pool_stream #(.CHANNELS(4), .DATA_WIDTH(16), .FEATURE_SIZE(3))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  global_avg_pool_stream #(.CHANNELS(4), .DATA_WIDTH(16), .FEATURE_SIZE(2), .RECIP(16385))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic               v, ordy;
  logic signed [15:0] din;
  logic [7:0]         ch, rw, cl;
  int                 sel;

  assign if0.valid_in = v && (sel == 0);
  assign if1.valid_in = v && (sel == 1);
  assign if2.valid_in = v && (sel == 2);
  assign if0.data_in = din;  assign if1.data_in = din;  assign if2.data_in = din;
  assign if0.channel_in = ch; assign if1.channel_in = ch; assign if2.channel_in = ch;
  assign if0.row_in = rw;    assign if1.row_in = rw;    assign if2.row_in = rw;
  assign if0.col_in = cl;    assign if1.col_in = cl;    assign if2.col_in = cl;
  assign if0.out_ready = ordy; assign if1.out_ready = ordy; assign if2.out_ready = ordy;

  logic               rdy, vo, fd;
  logic signed [15:0] dout;
  logic [7:0]         cout;

  always_comb begin
    case (sel)
      1: begin rdy = if1.ready; vo = if1.valid_out; dout = if1.data_out;
               cout = if1.channel_out; fd = if1.frame_done; end
      2: begin rdy = if2.ready; vo = if2.valid_out; dout = if2.data_out;
               cout = if2.channel_out; fd = if2.frame_done; end
      default: begin rdy = if0.ready; vo = if0.valid_out; dout = if0.data_out;
               cout = if0.channel_out; fd = if0.frame_done; end
    endcase
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]        sel;
    logic              junk;
    logic              use_seq;
    logic [3:0][15:0]  val;
    logic [3:0][15:0]  seq;
    logic [3:0][15:0]  exp;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [3:0][15:0] pk4(input int a, input int b, input int c, input int d);
    logic [3:0][15:0] r;
    r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
    return r;
  endfunction

  function automatic vec_t mkv(input int s, input bit j, input bit u,
                               input logic [3:0][15:0] val, input logic [3:0][15:0] seq,
                               input logic [3:0][15:0] exp);
    vec_t t;
    t.sel = 2'(s); t.junk = j; t.use_seq = u; t.val = val; t.seq = seq; t.exp = exp;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input int r, input int k, input logic signed [15:0] d);
    v = 1'b1; ch = 8'(c); rw = 8'(r); cl = 8'(k); din = d;
    step();
  endtask

  // Stream one frame, row-major, channels innermost; frame end is last.
  task automatic send_frame(input int s, input logic [3:0][15:0] val, input bit use_seq,
                            input logic [3:0][15:0] seq, input bit junk);
    int fsz;
    int pos;
    fsz = (s == 1) ? 3 : 2;
    pos = 0;
    sel = s;
    for (int r = 0; r < fsz; r++)
      for (int k = 0; k < fsz; k++) begin
        for (int c = 0; c < 4; c++) begin
          if (junk) drive(9, r, k, 16'sd12345);
          if (use_seq && c == 0 && pos < 4) drive(c, r, k, $signed(seq[pos]));
          else                              drive(c, r, k, $signed(val[c]));
        end
        pos++;
      end
    v = 1'b0;
  endtask

  // Called right after the frame-end edge; checks latency, order, pulse.
  task automatic check_drain(input logic [3:0][15:0] exp, input bit junk, input int fsz);
    if (junk) begin
      v = 1'b1; ch = 8'd0; rw = 8'(fsz - 1); cl = 8'(fsz - 1); din = 16'sd1000;
    end
    chk("latency_vo_low", int'(vo), 0);
    chk("drain_ready_low", int'(rdy), 0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", int'(vo), 1);
      chk("drain_channel", int'(cout), k);
      chk("drain_data", int'(dout), int'($signed(exp[k])));
      step();
    end
    v = 1'b0;
    chk("frame_done_pulse", int'(fd), 1);
    chk("post_valid_low", int'(vo), 0);
    chk("post_ready_high", int'(rdy), 1);
    step();
    chk("frame_done_single", int'(fd), 0);
  endtask

  initial begin
    rst_n = 1'b0; v = 1'b0; ordy = 1'b1; sel = 0; din = '0; ch = '0; rw = '0; cl = '0;

    // Hand-computed vectors (RECIP 16384 / 7281 / 16385 for sel 0 / 1 / 2).
    vecs[0] = mkv(0, 0, 0, pk4(100, 200, 300, 400), pk4(0, 0, 0, 0), pk4(100, 200, 300, 400));
    vecs[1] = mkv(0, 0, 1, pk4(0, 0, 0, 0), pk4(-1, -2, -3, -3), pk4(-3, 0, 0, 0));
    vecs[2] = mkv(0, 0, 0, pk4(-5, 7, 0, -32768), pk4(0, 0, 0, 0), pk4(-5, 7, 0, -32768));
    // FS=3: 9*32767*7281>>16 = 32763, 9*-32768*7281>>>16 = -32765, 9*7281>>16 = 0.
    vecs[3] = mkv(1, 0, 0, pk4(0, 32767, -32768, 1), pk4(0, 0, 0, 0), pk4(0, 32763, -32765, 0));
    // RECIP 16385 pushes full-scale sums past the rails: both clamp.
    vecs[4] = mkv(2, 0, 0, pk4(32767, -32768, 3, 100), pk4(0, 0, 0, 0), pk4(32767, -32768, 3, 100));
    vecs[5] = mkv(0, 1, 0, pk4(100, 200, 300, 400), pk4(0, 0, 0, 0), pk4(100, 200, 300, 400));
    vecs[6] = mkv(0, 0, 0, pk4(1, 2, 3, 4), pk4(0, 0, 0, 0), pk4(1, 2, 3, 4));

    step(); step();
    chk("reset_valid_out", int'(vo), 0);
    chk("reset_data_out", int'(dout), 0);
    chk("reset_channel_out", int'(cout), 0);
    chk("reset_frame_done", int'(fd), 0);
    chk("reset_ready", int'(rdy), 1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      send_frame(int'(vecs[i].sel), vecs[i].val, vecs[i].use_seq, vecs[i].seq, vecs[i].junk);
      check_drain(vecs[i].exp, vecs[i].junk, (vecs[i].sel == 2'd1) ? 3 : 2);
    end

    // Backpressure: stall on channel 1 for five cycles, then resume there.
    send_frame(0, pk4(11, 22, 33, 44), 1'b0, pk4(0, 0, 0, 0), 1'b0);
    step();
    chk("bp_ch0_data", int'(dout), 11);
    step();
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", int'(vo), 1);
      chk("bp_hold_channel", int'(cout), 1);
      chk("bp_hold_data", int'(dout), 22);
      step();
    end
    chk("bp_resume_channel", int'(cout), 1);
    ordy = 1'b1;
    step();
    chk("bp_ch2_channel", int'(cout), 2);
    chk("bp_ch2_data", int'(dout), 33);
    step();
    chk("bp_ch3_data", int'(dout), 44);
    step();
    chk("bp_frame_done", int'(fd), 1);
    step();

    // Reset mid-drain after two results, then a clean frame of 10s.
    send_frame(0, pk4(50, 50, 50, 50), 1'b0, pk4(0, 0, 0, 0), 1'b0);
    step(); step(); step();
    chk("mid_drain_channel", int'(cout), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid_out", int'(vo), 0);
    chk("async_rst_data_out", int'(dout), 0);
    chk("async_rst_channel_out", int'(cout), 0);
    chk("async_rst_frame_done", int'(fd), 0);
    chk("async_rst_ready", int'(rdy), 1);
    step();
    rst_n = 1'b1;
    step();
    send_frame(0, pk4(10, 10, 10, 10), 1'b0, pk4(0, 0, 0, 0), 1'b0);
    check_drain(pk4(10, 10, 10, 10), 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
